// File: rtl/led_string_tx.sv
// WS2812-class multi-string transmitter: shared bit timer, one-beat holding
// register for gapless streaming, and an on-request latch/reset pulse.
module led_string_tx #(
    parameter int CLK_PERIOD_NS = 100,
    parameter int NUM_STRINGS   = 4,
    parameter int PIXEL_BITS    = 24,
    parameter int T0H_NS        = 400,
    parameter int T1H_NS        = 800,
    parameter int T0L_NS        = 850,
    parameter int T1L_NS        = 450,
    parameter int RESET_NS      = 50000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_STRINGS*PIXEL_BITS-1:0] pixel_data,
    input  logic                              pixel_valid,
    output logic                              pixel_ready,
    input  logic                              blank_req,
    output logic                              busy,
    output logic [NUM_STRINGS-1:0]            sdi
);

    localparam int DW      = NUM_STRINGS * PIXEL_BITS;
    localparam int T0H_CNT = (T0H_NS + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
    localparam int T1H_CNT = (T1H_NS + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
    localparam int T0L_CNT = (T0L_NS + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
    localparam int T1L_CNT = (T1L_NS + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
    localparam int RST_CNT = (RESET_NS + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
    localparam int B0_CNT  = T0H_CNT + T0L_CNT;
    localparam int B1_CNT  = T1H_CNT + T1L_CNT;
    localparam int BIT_CNT = (B0_CNT > B1_CNT) ? B0_CNT : B1_CNT;
    localparam int MAX_A   = (BIT_CNT > RST_CNT) ? BIT_CNT : RST_CNT;
    localparam int MAX_C   = (MAX_A > PIXEL_BITS) ? MAX_A : PIXEL_BITS;
    localparam int CW      = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] T0H_C    = CW'(T0H_CNT);
    localparam logic [CW-1:0] T1H_C    = CW'(T1H_CNT);
    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CNT - 1);
    localparam logic [CW-1:0] PIX_LAST = CW'(PIXEL_BITS - 1);
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_RESET
    } state_t;

    state_t                 state, state_nxt;
    logic [DW-1:0]          hold_data, hold_nxt;
    logic                   hold_full, hold_full_nxt;
    logic                   blank_pending, pend_nxt;
    logic [DW-1:0]          shreg, shreg_nxt, shifted;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic [CW-1:0]          bit_idx, bit_nxt;
    logic [CW-1:0]          rcnt, rcnt_nxt;
    logic [NUM_STRINGS-1:0] sdi_nxt;
    logic                   accept;
    logic                   blank_take;

    assign pixel_ready = !hold_full && !blank_pending;
    assign busy        = (state != ST_IDLE) || hold_full || blank_pending;
    assign accept      = pixel_valid && pixel_ready;
    assign blank_take  = blank_req && !blank_pending && (state != ST_RESET);

    // Per-channel left shift so bits never leak between strings
    always_comb begin
        shifted = '0;
        for (int i = 0; i < NUM_STRINGS; i++) begin
            shifted[i*PIXEL_BITS +: PIXEL_BITS] =
                {shreg[i*PIXEL_BITS +: PIXEL_BITS-1], 1'b0};
        end
    end

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_nxt     = state;
        hold_nxt      = hold_data;
        hold_full_nxt = hold_full;
        pend_nxt      = blank_pending;
        shreg_nxt     = shreg;
        cnt_nxt       = cnt;
        bit_nxt       = bit_idx;
        rcnt_nxt      = rcnt;
        sdi_nxt       = '0;

        if (accept) begin
            hold_nxt      = pixel_data;
            hold_full_nxt = 1'b1;
        end
        if (blank_take) begin
            pend_nxt = 1'b1;
        end

        unique case (state)
            ST_IDLE: begin
                if (hold_full) begin
                    shreg_nxt     = hold_data;
                    hold_full_nxt = 1'b0;
                    cnt_nxt       = '0;
                    bit_nxt       = '0;
                    state_nxt     = ST_SHIFT;
                end else if (accept) begin
                    // Empty pipe: bypass the hold register for minimum latency
                    shreg_nxt     = pixel_data;
                    hold_full_nxt = 1'b0;
                    cnt_nxt       = '0;
                    bit_nxt       = '0;
                    state_nxt     = ST_SHIFT;
                end else if (blank_pending || blank_take) begin
                    rcnt_nxt  = '0;
                    state_nxt = ST_RESET;
                end
            end
            ST_SHIFT: begin
                for (int i = 0; i < NUM_STRINGS; i++) begin
                    sdi_nxt[i] = cnt < (shreg[i*PIXEL_BITS + PIXEL_BITS-1]
                                        ? T1H_C : T0H_C);
                end
                if (cnt == BIT_LAST) begin
                    cnt_nxt = '0;
                    if (bit_idx == PIX_LAST) begin
                        bit_nxt = '0;
                        if (hold_full) begin
                            shreg_nxt     = hold_data;
                            hold_full_nxt = 1'b0;
                        end else if (accept) begin
                            shreg_nxt     = pixel_data;
                            hold_full_nxt = 1'b0;
                        end else if (blank_pending || blank_take) begin
                            rcnt_nxt  = '0;
                            state_nxt = ST_RESET;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        shreg_nxt = shifted;
                        bit_nxt   = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_RESET: begin
                if (rcnt == RST_LAST) begin
                    state_nxt = ST_IDLE;
                end else begin
                    rcnt_nxt = rcnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // The latch request is consumed as RESET begins
        if ((state_nxt == ST_RESET) && (state != ST_RESET)) begin
            pend_nxt = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            hold_data     <= '0;
            hold_full     <= 1'b0;
            blank_pending <= 1'b0;
            shreg         <= '0;
            cnt           <= '0;
            bit_idx       <= '0;
            rcnt          <= '0;
            sdi           <= '0;
        end else begin
            state         <= state_nxt;
            hold_data     <= hold_nxt;
            hold_full     <= hold_full_nxt;
            blank_pending <= pend_nxt;
            shreg         <= shreg_nxt;
            cnt           <= cnt_nxt;
            bit_idx       <= bit_nxt;
            rcnt          <= rcnt_nxt;
            sdi           <= sdi_nxt;
        end
    end

endmodule
